// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
// The fetch unit is the master; the memory (or its model) is the slave.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches one word per fetch_go over
// the imem req/ack bus, and defers PC updates that arrive mid-fetch.
//
//   state | meaning
//   IDLE  | no request outstanding; fetch_go and pc_write act immediately
//   FETCH | imem_req held with imem_addr=pc until imem_ack
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] RESET_IR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       fetch_go,
  input  logic                       pc_write,
  input  logic                       pc_src,
  input  logic [31:0]                target_addr,
  instr_fetch_unit_if.master         imem,
  output logic [31:0]                instr,
  output logic                       instr_valid,
  output logic [31:0]                pc,
  output logic [31:0]                pc_plus4,
  output logic                       busy,
  output logic                       misalign_err,
  output logic [31:0]                fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] upd_val;
  logic        upd_ok;
  logic        ack_hit;

  assign pc_plus4 = pc_q + 32'd4;
  assign ack_hit  = (state_q == FETCH) && imem.imem_ack;

  // Resolve the candidate PC; a target with bit1 set is rejected, never applied.
  always_comb begin
    upd_val = pc_plus4;
    upd_ok  = 1'b1;
    if (pc_src) begin
      upd_val = target_addr & ~32'h1;
      upd_ok  = ~target_addr[1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= RESET_IR;
      pend_q   <= 32'd0;
      pend_v_q <= 1'b0;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
      cnt_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      valid_q  <= valid_d;
      mis_q    <= mis_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = IDLE;
    pc_d     = pc_q;
    ir_d     = ir_q;
    pend_d   = pend_q;
    pend_v_d = 1'b0;
    valid_d  = 1'b0;
    cnt_d    = cnt_q;
    mis_d    = mis_q | (pc_write & pc_src & target_addr[1]);

    case (state_q)
      IDLE: begin
        state_d = fetch_go ? FETCH : IDLE;
        if (pc_write && upd_ok) pc_d = upd_val;
      end
      FETCH: begin
        if (imem.imem_ack) begin
          state_d = IDLE;
          ir_d    = imem.imem_rdata;
          cnt_d   = cnt_q + 32'd1;
          valid_d = 1'b1;
          // A write on the ack edge wins; the pending value is dropped either way.
          if (pc_write) begin
            if (upd_ok) pc_d = upd_val;
          end else if (pend_v_q) begin
            pc_d = pend_q;
          end
        end else begin
          state_d  = FETCH;
          pend_v_d = pend_v_q;
          if (pc_write && upd_ok) begin
            pend_d   = upd_val;
            pend_v_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (pc_write && upd_ok) pc_d = upd_val;
      end
    endcase
  end

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;
  assign busy           = (state_q == FETCH);
  assign instr          = ir_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign misalign_err   = mis_q;
  assign fetch_count    = cnt_q;

  logic unused_ack_hit;
  assign unused_ack_hit = ack_hit;

endmodule
